uart_rx_sipo: RTL and testbench
===============================

# uart_rx_sipo

Serial-in/parallel-out receive shift register for the UART Rx path, mirroring the Tx parallel-in/serial-out register. Oversamples the serial line at 16x the bit rate, detects and validates the start bit, and shifts in 5–8 data bits LSB first. It then checks optional odd/even parity and one stop bit. Each received character is presented as a right-aligned parallel word with a one-cycle `data_valid` strobe and error flags.

## Interface
- OVERSAMPLE, 16, `baud_clk` cycles per bit; even, ≥4
- baud_clk  in  1  clock at OVERSAMPLE × bit rate; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- serial_data_in  in  1  asynchronous UART line; idles high
- data_length  in  4  data bits per character; 5–8 valid; 0–4 treated as 5, 9–15 as 8
- parity_type  in  2  0 = none, 1 = odd, 2 = even, 3 = none
- data_out  out  8  received word, right-aligned, unused upper bits 0
- data_valid  out  1  one-cycle pulse: new `data_out` and error flags valid
- parity_error  out  1  parity mismatch on last character
- framing_error  out  1  stop bit sampled low on last character
- busy  out  1  high whenever state ≠ IDLE

## Operation
- `serial_data_in` passes through a 2-flop synchronizer (`rx_s`). Both flops reset to 1.
- `data_length` and `parity_type` are latched when leaving IDLE. Mid-character input changes are ignored.
- Bit counter `cnt` has width clog2(OVERSAMPLE). Bit index `idx` is 3 bits.
- States:
  - **IDLE**: if `rx_s` = 0, go to START with `cnt` = 0.
  - **START**: increment `cnt`. When `cnt` = OVERSAMPLE/2−1, sample `rx_s`:
    - 0 → DATA, `cnt` = 0, `idx` = 0.
    - 1 → false start; return to IDLE with no strobe and no flag change.
  - **DATA**: when `cnt` = OVERSAMPLE−1, sample `rx_s` into bit `idx` of the shift register and set `cnt` = 0.
    - After bit `data_length`−1, go to PARITY if parity is enabled, else to STOP.
  - **PARITY**: sample at `cnt` = OVERSAMPLE−1.
    - Odd parity: the XOR of data bits and the parity bit must be 1.
    - Even parity: that XOR must be 0.
    - Then go to STOP.
  - **STOP**: sample at `cnt` = OVERSAMPLE−1.
    - Update `data_out`, `parity_error` and `framing_error`, and pulse `data_valid` on the next cycle.
    - Stop sampled 1 → IDLE.
    - Stop sampled 0 → BREAK_WAIT.
  - **BREAK_WAIT**: stay until `rx_s` = 1, then go to IDLE. This prevents a held-low line from re-triggering a start.
- Returning to IDLE at the mid-stop sample lets back-to-back characters be received with no idle gap.
- Flags and `data_out` hold their values until the next `data_valid`. `parity_error` is forced to 0 when parity is disabled.
- Unused upper bits of `data_out` are 0 (e.g. 5-bit mode gives `data_out[7:5]` = 0).

## Timing
- Reset values: `data_out` = 0, `data_valid` = 0, `parity_error` = 0, `framing_error` = 0, `busy` = 0, state = IDLE, synchronizer = 1.
- Reset asserted mid-character aborts immediately: no strobe, all outputs return to reset values on the next edge.
- Let E be the first cycle with state = START. E is 3 cycles after the raw falling edge: 2 synchronizer flops plus the IDLE decision.
  - Start sample at E+OVERSAMPLE/2−1.
  - Bit k sample at E+OVERSAMPLE/2−1+OVERSAMPLE·(k+1).
- With N data bits and P = 1 if parity is enabled (else 0):
  - Stop sample at E+OVERSAMPLE/2−1+OVERSAMPLE·(N+P+1).
  - `data_valid` is high exactly 1 cycle later.
- `busy` rises at E. It falls on the cycle after the stop sample, or after the false-start sample.
- `data_valid` never asserts on two consecutive cycles.

## Test plan
- **8N1**: 0xA5 LSB first, OVERSAMPLE = 16, parity off.
  - Expect `data_out` = 0xA5 with both error flags 0.
  - `data_valid` asserts exactly E+7+144+1.
- **8O1**: 0x88 with parity bit 1 → `data_out` = 0x88, `parity_error` = 0. Same frame with parity bit 0 → `parity_error` = 1.
- **7E1**: `data_length` = 7, `parity_type` = 2, data 0x48, parity bit 0 → `data_out` = 0x48, no errors. Then 5-bit 0x1F → `data_out` = 0x1F.
- **False start and break**:
  - A 4-cycle low glitch → no `data_valid`, `busy` falls after the mid-start sample.
  - A frame with stop bit 0 and line held low for 40 cycles → `framing_error` = 1, one strobe only, no new start until the line returns high.
- **Back-to-back and reset**:
  - Two 8N1 characters 0x31 and 0xC4 with no idle gap → two strobes 160 cycles apart, both correct.
  - `reset` asserted during bit 3 of a third frame → outputs return to 0, no strobe. The next clean frame 0x5A is received correctly.

Source files
------------

// File: rtl/uart_rx_sipo.sv
// UART receive shift register: 16x-oversampled start detection, 5-8 LSB-first
// data bits, optional odd/even parity, one stop bit, parallel word plus strobe.
module uart_rx_sipo #(
  parameter int OVERSAMPLE = 16
) (
  input  logic       baud_clk,
  input  logic       reset,
  input  logic       serial_data_in,
  input  logic [3:0] data_length,
  input  logic [1:0] parity_type,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       parity_error,
  output logic       framing_error,
  output logic       busy
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] HALF = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK_WAIT
  } state_e;

  state_e state_q, state_d;

  logic          sync_q, rx_s_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    last_idx_q, last_idx_d;
  logic [1:0]    ptype_q, ptype_d;
  logic          pbit_q, pbit_d;
  logic [7:0]    data_out_q, data_out_d;
  logic          valid_q, valid_d;
  logic          perr_q, perr_d;
  logic          ferr_q, ferr_d;

  logic       at_half, at_last, par_en;
  logic       sample_data, sample_parity, sample_stop;
  logic [2:0] len_last;

  assign at_half = (cnt_q == HALF);
  assign at_last = (cnt_q == LAST);
  assign par_en  = (ptype_q == 2'd1) || (ptype_q == 2'd2);

  // Out-of-range lengths clamp to the nearest legal width (5 or 8 bits).
  always_comb begin
    if (data_length <= 4'd5)      len_last = 3'd4;
    else if (data_length >= 4'd8) len_last = 3'd7;
    else                          len_last = (data_length == 4'd6) ? 3'd5 : 3'd6;
  end

  always_ff @(posedge baud_clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:       if (!rx_s_q) state_d = START;
      START:      if (at_half) state_d = rx_s_q ? IDLE : DATA;
      DATA:       if (at_last && idx_q == last_idx_q) state_d = par_en ? PARITY : STOP;
      PARITY:     if (at_last) state_d = STOP;
      STOP:       if (at_last) state_d = rx_s_q ? IDLE : BREAK_WAIT;
      BREAK_WAIT: if (rx_s_q) state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    busy          = (state_q != IDLE);
    sample_data   = (state_q == DATA)   && at_last;
    sample_parity = (state_q == PARITY) && at_last;
    sample_stop   = (state_q == STOP)   && at_last;
  end

  always_comb begin
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    last_idx_d = last_idx_q;
    ptype_d    = ptype_q;
    pbit_d     = pbit_q;
    data_out_d = data_out_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    valid_d    = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s_q) begin
          last_idx_d = len_last;
          ptype_d    = parity_type;
        end
      end
      START: begin
        cnt_d = cnt_q + ONE;
        if (at_half) begin
          cnt_d   = '0;
          idx_d   = '0;
          shift_d = '0;
        end
      end
      DATA, PARITY, STOP: cnt_d = at_last ? '0 : cnt_q + ONE;
      default:            cnt_d = '0;
    endcase

    if (sample_data) begin
      shift_d[idx_q] = rx_s_q;
      idx_d          = idx_q + 3'd1;
    end
    if (sample_parity) pbit_d = rx_s_q;

    // XOR of data and parity bit must be 1 for odd, 0 for even.
    if (sample_stop) begin
      data_out_d = shift_q;
      perr_d     = par_en & ((^shift_q) ^ pbit_q ^ (ptype_q == 2'd1));
      ferr_d     = ~rx_s_q;
      valid_d    = 1'b1;
    end
  end

  always_ff @(posedge baud_clk) begin
    if (reset) begin
      sync_q     <= 1'b1;
      rx_s_q     <= 1'b1;
      cnt_q      <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      last_idx_q <= 3'd7;
      ptype_q    <= 2'd0;
      pbit_q     <= 1'b0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      sync_q     <= serial_data_in;
      rx_s_q     <= sync_q;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      last_idx_q <= last_idx_d;
      ptype_q    <= ptype_d;
      pbit_q     <= pbit_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
    end
  end

  assign data_out      = data_out_q;
  assign data_valid    = valid_q;
  assign parity_error  = perr_q;
  assign framing_error = ferr_q;

endmodule

// File: tb/tb_uart_rx_sipo.sv
// Self-checking bench for uart_rx_sipo: frame-level model predicts strobe
// cycle and contents of every character; literal checks pin that model.
module tb_uart_rx_sipo;

  localparam int OS = 16;

  logic       baud_clk = 1'b0;
  logic       reset;
  logic       serial_data_in;
  logic [3:0] data_length;
  logic [1:0] parity_type;
  logic [7:0] data_out;
  logic       data_valid;
  logic       parity_error;
  logic       framing_error;
  logic       busy;

  uart_rx_sipo #(.OVERSAMPLE(OS)) dut (
    .baud_clk      (baud_clk),
    .reset         (reset),
    .serial_data_in(serial_data_in),
    .data_length   (data_length),
    .parity_type   (parity_type),
    .data_out      (data_out),
    .data_valid    (data_valid),
    .parity_error  (parity_error),
    .framing_error (framing_error),
    .busy          (busy)
  );

  always #5 baud_clk = ~baud_clk;

  typedef struct {
    int         cyc;
    logic [7:0] d;
    logic       pe;
    logic       fe;
    logic       b;
  } exp_t;

  exp_t q[$];

  int   cyc = 0;
  logic rstAtEdge = 1'b0;
  int   checkCount = 0;
  int   passCount = 0;
  int   validCount = 0;
  int   lastValidCyc = -1;
  int   prevValidCyc = -1;
  logic [7:0] expData = '0;
  logic expPe = 1'b0;
  logic expFe = 1'b0;
  logic expValid;

  always @(posedge baud_clk) begin
    cyc       <= cyc + 1;
    rstAtEdge <= reset;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act !== exp)
      $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    else
      passCount++;
  endtask

  // Compare process: every cycle, strobe timing and held outputs against the model.
  always @(negedge baud_clk) begin
    if (cyc > 0) begin
      if (rstAtEdge) begin
        q.delete();
        expData = '0;
        expPe   = 1'b0;
        expFe   = 1'b0;
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_data_valid", data_valid, 0);
      end else begin
        expValid = (q.size() > 0) && (q[0].cyc == cyc);
        checkOutput("data_valid", data_valid, expValid);
        if (data_valid) begin
          validCount++;
          prevValidCyc = lastValidCyc;
          lastValidCyc = cyc;
        end
        if (expValid) begin
          expData = q[0].d;
          expPe   = q[0].pe;
          expFe   = q[0].fe;
          checkOutput("busy_at_strobe", busy, q[0].b);
          void'(q.pop_front());
        end
      end
      checkOutput("data_out", data_out, expData);
      checkOutput("parity_error", parity_error, expPe);
      checkOutput("framing_error", framing_error, expFe);
    end
  end

  task automatic holdBit(input logic b);
    serial_data_in = b;
    repeat (OS) @(negedge baud_clk);
  endtask

  task automatic idle(input int n);
    serial_data_in = 1'b1;
    repeat (n) @(negedge baud_clk);
  endtask

  // Drives one frame and records what the receiver must report for it.
  task automatic applyStimulus(input logic [7:0] d, input logic [3:0] len, input logic [1:0] pt,
                               input logic pbit, input logic stopBit, output int p);
    int         n;
    int         ones;
    bit         pen;
    logic [7:0] m;
    exp_t       e;
    n    = (len < 4'd5) ? 5 : (len > 4'd8) ? 8 : int'(len);
    pen  = (pt == 2'd1) || (pt == 2'd2);
    m    = 8'((1 << n) - 1);
    ones = $countones(d & m);
    data_length = len;
    parity_type = pt;
    p    = cyc;
    e.cyc = p + 3 + (OS / 2 - 1) + OS * (n + int'(pen) + 1) + 1;
    e.d   = d & m;
    e.pe  = pen && ((pt == 2'd1) ? (((ones + int'(pbit)) % 2) != 1)
                                 : (((ones + int'(pbit)) % 2) != 0));
    e.fe  = ~stopBit;
    e.b   = ~stopBit;
    q.push_back(e);
    holdBit(1'b0);
    for (int i = 0; i < n; i++) holdBit(d[i]);
    if (pen) holdBit(pbit);
    holdBit(stopBit);
  endtask

  initial begin
    int p, p2, vc;
    reset          = 1'b1;
    serial_data_in = 1'b1;
    data_length    = 4'd8;
    parity_type    = 2'd0;
    repeat (4) @(negedge baud_clk);
    checkOutput("lit_reset_data_out", data_out, 8'h00);
    checkOutput("lit_reset_busy", busy, 0);
    reset = 1'b0;
    idle(10);

    $display("[TB] 8N1 0xA5");
    applyStimulus(8'hA5, 4'd8, 2'd0, 1'b0, 1'b1, p);
    checkOutput("lit_8n1_data", data_out, 8'hA5);
    checkOutput("lit_8n1_strobe_cycle", lastValidCyc, p + 3 + 7 + 144 + 1);
    idle(20);

    $display("[TB] 8O1 0x88");
    applyStimulus(8'h88, 4'd8, 2'd1, 1'b1, 1'b1, p);
    checkOutput("lit_8o1_good_perr", parity_error, 0);
    idle(20);
    applyStimulus(8'h88, 4'd8, 2'd1, 1'b0, 1'b1, p);
    checkOutput("lit_8o1_bad_perr", parity_error, 1);
    checkOutput("lit_8o1_bad_data", data_out, 8'h88);
    idle(20);

    $display("[TB] 7E1 and short words");
    applyStimulus(8'h48, 4'd7, 2'd2, 1'b0, 1'b1, p);
    checkOutput("lit_7e1_data", data_out, 8'h48);
    checkOutput("lit_7e1_perr", parity_error, 0);
    idle(20);
    applyStimulus(8'h1F, 4'd5, 2'd0, 1'b0, 1'b1, p);
    checkOutput("lit_5n1_data", data_out, 8'h1F);
    idle(20);
    applyStimulus(8'hFF, 4'd3, 2'd2, 1'b1, 1'b1, p);
    checkOutput("lit_len3_data", data_out, 8'h1F);
    idle(20);
    applyStimulus(8'h3C, 4'd12, 2'd3, 1'b0, 1'b1, p);
    checkOutput("lit_len12_data", data_out, 8'h3C);
    idle(20);

    $display("[TB] false start glitch");
    vc = validCount;
    p  = cyc;
    serial_data_in = 1'b0;
    repeat (4) @(negedge baud_clk);
    serial_data_in = 1'b1;
    repeat (6) @(negedge baud_clk);
    checkOutput("lit_glitch_busy_before_sample", busy, 1);
    @(negedge baud_clk);
    checkOutput("lit_glitch_busy_after_sample", busy, 0);
    idle(20);
    checkOutput("lit_glitch_no_strobe", validCount - vc, 0);

    $display("[TB] break");
    vc = validCount;
    applyStimulus(8'h55, 4'd8, 2'd0, 1'b0, 1'b0, p);
    repeat (40) @(negedge baud_clk);
    checkOutput("lit_break_busy_held", busy, 1);
    checkOutput("lit_break_ferr", framing_error, 1);
    checkOutput("lit_break_one_strobe", validCount - vc, 1);
    idle(10);
    checkOutput("lit_break_released", busy, 0);
    idle(10);

    $display("[TB] back-to-back");
    applyStimulus(8'h31, 4'd8, 2'd0, 1'b0, 1'b1, p);
    applyStimulus(8'hC4, 4'd8, 2'd0, 1'b0, 1'b1, p2);
    checkOutput("lit_b2b_gap", lastValidCyc - prevValidCyc, 160);
    checkOutput("lit_b2b_data", data_out, 8'hC4);

    $display("[TB] reset mid-frame");
    vc = validCount;
    data_length = 4'd8;
    parity_type = 2'd0;
    holdBit(1'b0);
    holdBit(1'b1);
    holdBit(1'b1);
    holdBit(1'b0);
    serial_data_in = 1'b1;
    repeat (8) @(negedge baud_clk);
    reset = 1'b1;
    repeat (3) @(negedge baud_clk);
    checkOutput("lit_midreset_data_out", data_out, 8'h00);
    checkOutput("lit_midreset_busy", busy, 0);
    reset = 1'b0;
    idle(30);
    checkOutput("lit_midreset_no_strobe", validCount - vc, 0);
    applyStimulus(8'h5A, 4'd8, 2'd0, 1'b0, 1'b1, p);
    checkOutput("lit_after_reset_data", data_out, 8'h5A);
    idle(20);

    checkOutput("pending_strobes", q.size(), 0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
